// File: rtl/tx_arb_pkg.sv
// Shared definitions for the transmit arbiter: state encoding, parameter
// defaults and a one-hot to index helper.
package tx_arb_pkg;

  localparam int unsigned D_BIT_DEF     = 8;
  localparam int unsigned N_REQ_DEF     = 4;
  localparam int unsigned TO_CYCLES_DEF = 65535;
  localparam int unsigned MAX_REQ       = 8;
  localparam int unsigned MAX_IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  // Index of the set bit in a one-hot vector (zero when none is set).
  function automatic logic [MAX_IDX_W-1:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester found searching upward
// from i_ptr+1, wrapping modulo N_REQ.
module rr_picker #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_winner_c,
  output logic                     o_valid_c
);

  localparam int unsigned PW = $clog2(N_REQ);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_winner_c = '0;
    o_valid_c  = 1'b0;
    w_idx      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_idx = PW'((32'(i_ptr) + i) % N_REQ);
      if (!o_valid_c && i_req[w_idx]) begin
        o_winner_c[w_idx] = 1'b1;
        o_valid_c         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding one byte transmitter from N_REQ requesters;
// a grant is held for a whole message and released on last byte or timeout.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned D_BIT     = D_BIT_DEF,
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ-1:0]       i_last,
  input  logic [N_REQ*D_BIT-1:0] i_data,
  output logic [N_REQ-1:0]       o_ack,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_tx_start,
  output logic [D_BIT-1:0]       o_tx_data,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  arb_state_e         r_state, w_state;
  logic [N_REQ-1:0]   r_grant, w_grant;
  logic [N_REQ-1:0]   r_ack, w_ack;
  logic [PW-1:0]      r_owner, w_owner;
  logic [PW-1:0]      r_ptr, w_ptr;
  logic               r_last, w_last;
  logic               r_tx_start, w_tx_start;
  logic [D_BIT-1:0]   r_tx_data, w_tx_data;
  logic               r_busy, w_busy;
  logic               r_err, w_err;
  logic [CW-1:0]      r_cnt, w_cnt;

  logic [D_BIT-1:0]   w_bytes [N_REQ];
  logic [N_REQ-1:0]   w_pick_oh;
  logic               w_pick_valid;
  logic [PW-1:0]      w_pick_idx;
  logic [CW-1:0]      w_cnt_inc;
  logic               w_timeout;

  for (genvar k = 0; k < N_REQ; k++) begin : g_bytes
    assign w_bytes[k] = i_data[k*D_BIT +: D_BIT];
  end

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .i_req      (i_req),
    .i_ptr      (r_ptr),
    .o_winner_c (w_pick_oh),
    .o_valid_c  (w_pick_valid)
  );

  assign w_pick_idx = PW'(onehot_idx(MAX_REQ'(w_pick_oh)));
  assign w_cnt_inc  = r_cnt + CW'(1);
  // Timeout fires on the cycle the counter would step onto TO_CYCLES-1.
  assign w_timeout  = (w_cnt_inc >= TO_LAST);

  // Next-state and registered-output logic; LOAD-cycle outputs are
  // computed on the transition into LOAD so they are visible during LOAD.
  always_comb begin
    w_state    = r_state;
    w_grant    = r_grant;
    w_owner    = r_owner;
    w_ptr      = r_ptr;
    w_last     = r_last;
    w_ack      = '0;
    w_tx_start = 1'b0;
    w_tx_data  = r_tx_data;
    w_err      = 1'b0;
    w_cnt      = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state    = ST_LOAD;
          w_grant    = w_pick_oh;
          w_owner    = w_pick_idx;
          w_ack      = w_pick_oh;
          w_tx_start = 1'b1;
          w_tx_data  = w_bytes[w_pick_idx];
          w_last     = i_last[w_pick_idx];
          w_cnt      = '0;
        end
      end

      ST_LOAD: begin
        w_state = ST_WAIT;
        w_cnt   = '0;
      end

      ST_WAIT: begin
        w_cnt = w_cnt_inc;
        if (i_tx_done) begin
          if (!r_last && i_req[r_owner]) begin
            w_state    = ST_LOAD;
            w_ack      = r_grant;
            w_tx_start = 1'b1;
            w_tx_data  = w_bytes[r_owner];
            w_last     = i_last[r_owner];
            w_cnt      = '0;
          end else begin
            w_state = ST_IDLE;
            w_grant = '0;
            w_ptr   = r_owner;
          end
        end else if (w_timeout) begin
          w_state = ST_IDLE;
          w_grant = '0;
          w_ptr   = r_owner;
          w_err   = 1'b1;
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_grant = '0;
      end
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_ack      <= '0;
      r_owner    <= '0;
      r_ptr      <= PW'(N_REQ - 1);
      r_last     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state;
      r_grant    <= w_grant;
      r_ack      <= w_ack;
      r_owner    <= w_owner;
      r_ptr      <= w_ptr;
      r_last     <= w_last;
      r_tx_start <= w_tx_start;
      r_tx_data  <= w_tx_data;
      r_busy     <= w_busy;
      r_err      <= w_err;
      r_cnt      <= w_cnt;
    end
  end

  assign o_ack      = r_ack;
  assign o_grant    = r_grant;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;
  assign o_err      = r_err;

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter D_BIT, default 8, data bits per byte; equals the transmitter's D_BIT.
REQ-002 Parameter N_REQ, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter TO_CYCLES, default 65535, maximum clocks to wait for i_tx_done before aborting.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 i_clock  in  1  sole clock; all logic on its rising edge.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 i_req  in  N_REQ  per-requester byte-available level.
REQ-008 i_last  in  N_REQ  per-requester "this byte ends the message" flag, qualified by i_req.
REQ-009 i_data  in  N_REQ*D_BIT  flattened bytes; requester k occupies bits [k*D_BIT +: D_BIT].
REQ-010 o_ack  out  N_REQ  one-cycle pulse; the requester's byte was captured.
REQ-011 o_grant  out  N_REQ  one-hot owner of the transmitter; all zero when free.
REQ-012 o_tx_start  out  1  one-cycle start pulse to the transmitter.
REQ-013 o_tx_data  out  D_BIT  byte to the transmitter, stable from the start pulse to done.
REQ-014 i_tx_done  in  1  transmitter end-of-frame pulse.
REQ-015 o_busy  out  1  high whenever state is not IDLE.
REQ-016 o_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD and WAIT; all outputs SHALL be registered.
REQ-018 IDLE: if any i_req bit is high, the winner SHALL be chosen by round-robin, searching from ptr+1 upward modulo N_REQ; o_grant is set to the winner and the next state is LOAD.
REQ-019 LOAD, exactly one cycle:
- o_tx_data captures the winner's i_data.
- Lock the winner's i_last.
- Pulse o_ack[winner] and o_tx_start together.
- Clear the timeout counter.
- Next state is WAIT.
REQ-020 Latency SHALL be 1 cycle from i_req rising in IDLE to o_tx_start.
REQ-021 WAIT: the timeout counter SHALL increment each cycle; on i_tx_done:
- Locked last = 1: clear the grant, set ptr = winner, go to IDLE.
- Locked last = 0 and i_req[winner] high: go to LOAD for the next byte.
- Locked last = 0 and i_req[winner] low: abort the message, clear the grant, set ptr = winner, go to IDLE.
REQ-022 The grant SHALL stay locked to one requester for a whole message; other requests are ignored until release.
REQ-023 If the counter reaches TO_CYCLES-1 in WAIT without i_tx_done:
- Pulse o_err.
- Clear the grant and set ptr = winner.
- Go to IDLE.
REQ-024 If i_tx_done and timeout occur in the same cycle, i_tx_done SHALL win and o_err SHALL NOT pulse.
REQ-025 i_tx_done outside WAIT SHALL be ignored.
REQ-026 o_ack SHALL never pulse for a non-granted requester, and at most one o_ack bit SHALL be high per cycle.
REQ-027 i_data, i_last and i_req changes on non-granted requesters SHALL have no effect.
REQ-028 A requester SHALL hold i_data and i_last stable until its o_ack; the arbiter samples them only in LOAD.

Reset
REQ-029 On i_reset the block SHALL set:
- state = IDLE, ptr = N_REQ-1 (requester 0 is favoured first);
- o_grant = 0, o_ack = 0, o_tx_start = 0, o_tx_data = 0;
- o_busy = 0, o_err = 0, timeout counter = 0.
REQ-030 Reset asserted mid-message SHALL abandon the message with no o_ack or o_err pulse in the reset cycle.

Structure
REQ-031 Package tx_arb_pkg SHALL hold the state encoding and the defaults for D_BIT, N_REQ and TO_CYCLES.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_picker(req, ptr -> one-hot winner, valid).
REQ-033 The timeout counter SHALL be $clog2(TO_CYCLES+1) bits wide.

Verification
REQ-034 The bench SHALL run against a transmitter model that pulses i_tx_done 20 cycles after o_tx_start; five scenarios.
- V1, single byte: after reset, i_req=0001, i_last[0]=1, data0=0x55 -> next cycle o_tx_start=1, o_tx_data=0x55, o_ack=0001; o_grant=0 one cycle after done.
- V2, fairness: i_req=1111 held with every i_last=1 -> grant order 0,1,2,3,0.
- V3, message lock: requester 2 sends 3 bytes (0xA1,0xA2,0xA3, last on the third) while i_req[0]=1 -> all three bytes go out consecutively before requester 0 is granted.
- V4, timeout: TO_CYCLES=50, i_tx_done suppressed -> o_err pulses exactly 50 cycles after o_tx_start and state returns to IDLE.
- V5, reset mid-WAIT and done/timeout tie: i_reset during WAIT -> all outputs at reset values the next cycle; i_tx_done on the timeout cycle -> no o_err.
